// File: rtl/rectifier_adc_sequencer.sv
// Sequences two AD7822 ADCs (Ibat then Vbat): CONVST pulse, EOC wait, CS/RD read, latch.
// Latency: one frame = 2*(CONVST_W + EOC wait + RD_W + 1) + 1 cycles after the trigger is sampled.
// No backpressure: triggers seen outside IDLE are dropped, o_valid is a one-cycle pulse.
module rectifier_adc_sequencer #(
  parameter int CONVST_W = 4,
  parameter int RD_W     = 3,
  parameter int TIMEOUT  = 200
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_trigger,
  input  logic       i_clear_err,
  input  logic [1:0] i_ADC_EOC_n,
  input  logic [7:0] i_ADC_DB,
  output logic [1:0] o_ADC_CONVST_n,
  output logic [1:0] o_ADC_CS_n,
  output logic [1:0] o_ADC_RD_n,
  output logic [7:0] o_Ibat_ADC,
  output logic [7:0] o_Vbat_ADC,
  output logic       o_valid,
  output logic       o_busy,
  output logic [1:0] o_timeout
);

  // Terminal counts for the 8-bit phase counter; each phase ends when cnt hits its *_LAST.
  localparam logic [7:0] CONV_LAST = 8'(CONVST_W - 1);
  localparam logic [7:0] RD_LAST   = 8'(RD_W - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_WAIT_EOC,
    S_READ,
    S_NEXT,
    S_DONE
  } state_t;

  state_t     state;
  logic       ch;
  logic [7:0] cnt;
  logic [1:0] eoc_meta;
  logic [1:0] eoc_sync;

  // Saturating increment so a long stall can never wrap the counter back to a terminal count.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Active-low strobe pattern selecting only the given channel.
  function automatic logic [1:0] ch_low(input logic c);
    return c ? 2'b01 : 2'b10;
  endfunction

  // Two-flop synchronizer for the asynchronous EOC lines; idles high (no conversion done).
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      eoc_meta <= 2'b11;
      eoc_sync <= 2'b11;
    end else begin
      eoc_meta <= i_ADC_EOC_n;
      eoc_sync <= eoc_meta;
    end
  end

  // Frame FSM with registered strobes; strobes change on state entry so their low
  // width equals the number of cycles spent in CONV or READ.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= S_IDLE;
      ch             <= 1'b0;
      cnt            <= 8'd0;
      o_ADC_CONVST_n <= 2'b11;
      o_ADC_CS_n     <= 2'b11;
      o_ADC_RD_n     <= 2'b11;
      o_Ibat_ADC     <= 8'd0;
      o_Vbat_ADC     <= 8'd0;
      o_valid        <= 1'b0;
      o_busy         <= 1'b0;
      o_timeout      <= 2'b00;
    end else begin
      o_valid <= 1'b0;
      // Clear first so a timeout set later in this block overrides it.
      if (i_clear_err) o_timeout <= 2'b00;

      case (state)
        S_IDLE: begin
          if (i_trigger) begin
            state          <= S_CONV;
            ch             <= 1'b0;
            cnt            <= 8'd0;
            o_ADC_CONVST_n <= ch_low(1'b0);
            o_busy         <= 1'b1;
          end
        end

        S_CONV: begin
          if (cnt == CONV_LAST) begin
            o_ADC_CONVST_n <= 2'b11;
            cnt            <= 8'd0;
            state          <= S_WAIT_EOC;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        S_WAIT_EOC: begin
          if (!eoc_sync[ch]) begin
            state      <= S_READ;
            cnt        <= 8'd0;
            o_ADC_CS_n <= ch_low(ch);
            o_ADC_RD_n <= ch_low(ch);
          end else if (cnt == TO_LAST) begin
            // Give up on this channel; its last good code stays in place.
            o_timeout[ch] <= 1'b1;
            state         <= S_NEXT;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        S_READ: begin
          if (cnt == RD_LAST) begin
            if (ch) o_Vbat_ADC <= i_ADC_DB;
            else    o_Ibat_ADC <= i_ADC_DB;
            o_ADC_CS_n <= 2'b11;
            o_ADC_RD_n <= 2'b11;
            state      <= S_NEXT;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        S_NEXT: begin
          if (!ch) begin
            ch             <= 1'b1;
            cnt            <= 8'd0;
            o_ADC_CONVST_n <= ch_low(1'b1);
            state          <= S_CONV;
          end else begin
            o_valid <= 1'b1;
            state   <= S_DONE;
          end
        end

        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          o_ADC_CONVST_n <= 2'b11;
          o_ADC_CS_n     <= 2'b11;
          o_ADC_RD_n     <= 2'b11;
          o_busy         <= 1'b0;
          state          <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rectifier_adc_sequencer.sv
// Bench for rectifier_adc_sequencer: behavioural AD7822 pair, per-cycle strobe checks,
// directed frames (nominal, timeout, held trigger, reset abort) and random frames.
// Stimulus is applied 2 ns after each rising edge; the monitor samples on the falling edge.
`timescale 1ns/1ps
module tb_rectifier_adc_sequencer;

  localparam int CONVST_W = 4;
  localparam int RD_W     = 3;
  localparam int TIMEOUT  = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic       clr;
  logic [1:0] eoc_n = 2'b11;
  logic [7:0] db;
  logic [1:0] conv_n, cs_n, rd_n, tmo;
  logic [7:0] ibat, vbat;
  logic       vld, busy;

  always #5 clk = ~clk;

  rectifier_adc_sequencer #(.CONVST_W(CONVST_W), .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clock(clk), .i_reset(rst), .i_trigger(trig), .i_clear_err(clr),
    .i_ADC_EOC_n(eoc_n), .i_ADC_DB(db),
    .o_ADC_CONVST_n(conv_n), .o_ADC_CS_n(cs_n), .o_ADC_RD_n(rd_n),
    .o_Ibat_ADC(ibat), .o_Vbat_ADC(vbat), .o_valid(vld), .o_busy(busy), .o_timeout(tmo)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- ADC pair model ----------------
  logic [1:0] adc_en = 2'b11;
  int         adc_dly [2] = '{10, 10};
  logic [7:0] adc_val [2] = '{8'h00, 8'h00};
  logic [1:0] prev_conv = 2'b11;
  int         cd [2] = '{0, 0};

  assign db = !rd_n[0] ? adc_val[0] : (!rd_n[1] ? adc_val[1] : 8'h00);

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rd_n[c] === 1'b0) begin
        eoc_n[c] <= 1'b1;
        cd[c]    <= 0;
      end else if (prev_conv[c] === 1'b0 && conv_n[c] === 1'b1) begin
        if (adc_en[c]) cd[c] <= adc_dly[c];
      end else if (cd[c] > 0) begin
        if (cd[c] == 1) eoc_n[c] <= 1'b0;
        cd[c] <= cd[c] - 1;
      end
    end
    prev_conv <= conv_n;
  end

  // ---------------- Monitor ----------------
  bit   mon_on = 0;
  int   valid_cnt = 0;
  int   conv_pulses [2] = '{0, 0};
  int   rd_pulses [2] = '{0, 0};
  int   conv_w [2] = '{0, 0};
  int   rd_w [2] = '{0, 0};
  int   run_c [2] = '{0, 0};
  int   run_r [2] = '{0, 0};
  int   since1 = 0;
  int   lat1 = 0;
  int   idle_run = 0;
  int   gap_one = 0;
  int   gap_other = 0;
  logic conv1_q = 1'b1;

  always @(negedge clk) begin
    if (mon_on) begin
      check("one_strobe_low", $countones(~{conv_n, cs_n}) <= 1, 1);
      check("cs_eq_rd", {30'd0, cs_n}, {30'd0, rd_n});
      for (int c = 0; c < 2; c++) begin
        if (!conv_n[c]) run_c[c]++;
        else if (run_c[c] > 0) begin conv_w[c] = run_c[c]; conv_pulses[c]++; run_c[c] = 0; end
        if (!rd_n[c]) run_r[c]++;
        else if (run_r[c] > 0) begin rd_w[c] = run_r[c]; rd_pulses[c]++; run_r[c] = 0; end
      end
      if (conv_n[1] && !conv1_q) since1 = 1; else since1++;
      conv1_q = conv_n[1];
      if (vld) begin valid_cnt++; lat1 = since1; end
      if (!busy) idle_run++;
      else begin
        if (idle_run == 1) gap_one++;
        else if (idle_run > 1) gap_other++;
        idle_run = 0;
      end
    end
  end

  // ---------------- Reference state ----------------
  logic [7:0] exp_ibat = 8'h00;
  logic [7:0] exp_vbat = 8'h00;
  logic [1:0] exp_to = 2'b00;

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // One triggered frame; optional noise triggers while busy must be ignored.
  task automatic run_frame(input string tag, input logic [7:0] v0, input logic [7:0] v1,
                           input logic [1:0] en, input int d0, input int d1, input bit noise);
    int  b_valid, b_cp0, b_cp1, b_rp0, b_rp1;
    bit  done;
    adc_val[0] = v0; adc_val[1] = v1; adc_en = en; adc_dly[0] = d0; adc_dly[1] = d1;
    b_valid = valid_cnt;
    b_cp0 = conv_pulses[0]; b_cp1 = conv_pulses[1];
    b_rp0 = rd_pulses[0];   b_rp1 = rd_pulses[1];
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
    done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick(1);
      if (valid_cnt > b_valid) done = 1;
      else if (noise) trig = ($urandom_range(0, 3) == 0);
    end
    trig = 1'b0;
    check({tag, "_frame_completed"}, {31'd0, done}, 1);
    tick(5);
    if (en[0]) exp_ibat = v0; else exp_to[0] = 1'b1;
    if (en[1]) exp_vbat = v1; else exp_to[1] = 1'b1;
    check({tag, "_valid_pulses"}, valid_cnt - b_valid, 1);
    check({tag, "_conv0_pulses"}, conv_pulses[0] - b_cp0, 1);
    check({tag, "_conv1_pulses"}, conv_pulses[1] - b_cp1, 1);
    check({tag, "_conv0_width"}, conv_w[0], CONVST_W);
    check({tag, "_conv1_width"}, conv_w[1], CONVST_W);
    check({tag, "_rd0_pulses"}, rd_pulses[0] - b_rp0, {31'd0, en[0]});
    check({tag, "_rd1_pulses"}, rd_pulses[1] - b_rp1, {31'd0, en[1]});
    if (en[0]) check({tag, "_rd0_width"}, rd_w[0], RD_W);
    if (en[1]) check({tag, "_rd1_width"}, rd_w[1], RD_W);
    check({tag, "_ibat"}, {24'd0, ibat}, {24'd0, exp_ibat});
    check({tag, "_vbat"}, {24'd0, vbat}, {24'd0, exp_vbat});
    check({tag, "_timeout"}, {30'd0, tmo}, {30'd0, exp_to});
    check({tag, "_busy_after"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int  b_valid, b_g1, b_go, frames;
    bit  seen;

    rst = 1'b1; trig = 1'b0; clr = 1'b0;
    tick(3);
    check("rst_strobes", {26'd0, conv_n, cs_n, rd_n}, 32'h3F);
    check("rst_ibat", {24'd0, ibat}, 0);
    check("rst_vbat", {24'd0, vbat}, 0);
    check("rst_valid_busy", {30'd0, vld, busy}, 0);
    check("rst_timeout", {30'd0, tmo}, 0);
    rst = 1'b0;
    mon_on = 1;
    tick(2);

    // Nominal frame.
    run_frame("nominal", 8'h5A, 8'hC3, 2'b11, 10, 10, 0);

    // Vbat never converts: timeout after exactly TIMEOUT wait cycles, frame still completes.
    run_frame("vbat_timeout", 8'h77, 8'h99, 2'b01, 10, 10, 0);
    check("vbat_timeout_latency", lat1, TIMEOUT + 2);
    clr = 1'b1; tick(1); clr = 1'b0; exp_to = 2'b00;
    check("clear_err", {30'd0, tmo}, 0);

    // Trigger held high: three frames back to back with a single IDLE cycle between.
    adc_en = 2'b11; adc_dly[0] = 5; adc_dly[1] = 7;
    adc_val[0] = 8'h12; adc_val[1] = 8'h34;
    trig = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(1); if (busy) seen = 1; end
    check("held_busy_rise", {31'd0, seen}, 1);
    tick(1);
    b_valid = valid_cnt; b_g1 = gap_one; b_go = gap_other;
    frames = 0;
    for (int i = 0; i < 3000 && frames < 3; i++) begin
      if (vld) begin
        frames++;
        if (frames == 3) trig = 1'b0;
      end
      if (frames < 3) tick(1);
    end
    trig = 1'b0;
    tick(10);
    check("held_valid_count", valid_cnt - b_valid, 3);
    check("held_gap_one", gap_one - b_g1, 2);
    check("held_gap_other", gap_other - b_go, 0);
    exp_ibat = 8'h12; exp_vbat = 8'h34;
    check("held_ibat", {24'd0, ibat}, {24'd0, exp_ibat});
    check("held_vbat", {24'd0, vbat}, {24'd0, exp_vbat});

    // Random frames with triggers sprinkled while busy.
    for (int f = 0; f < 8; f++) begin
      logic [1:0] en;
      en[0] = ($urandom_range(0, 4) != 0);
      en[1] = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 2) == 0) begin
        clr = 1'b1; tick(1); clr = 1'b0; exp_to = 2'b00;
        check("rand_clear", {30'd0, tmo}, 0);
      end
      run_frame($sformatf("rand%0d", f), 8'($urandom), 8'($urandom), en,
                $urandom_range(1, 30), $urandom_range(1, 30), 1);
    end

    // Reset in the middle of the Vbat read aborts the frame.
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    exp_ibat = 8'h00; exp_vbat = 8'h00; exp_to = 2'b00;
    adc_en = 2'b11; adc_dly[0] = 10; adc_dly[1] = 10;
    adc_val[0] = 8'hA5; adc_val[1] = 8'h3C;
    b_valid = valid_cnt;
    trig = 1'b1; tick(1); trig = 1'b0;
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin tick(1); if (rd_n[1] === 1'b0) seen = 1; end
    check("abort_reached_read1", {31'd0, seen}, 1);
    rst = 1'b1;
    tick(1);
    check("abort_strobes", {26'd0, conv_n, cs_n, rd_n}, 32'h3F);
    check("abort_vbat", {24'd0, vbat}, 0);
    check("abort_valid_busy", {30'd0, vld, busy}, 0);
    rst = 1'b0;
    tick(20);
    check("abort_no_valid", valid_cnt - b_valid, 0);
    check("abort_idle", {31'd0, busy}, 0);
    check("abort_vbat_later", {24'd0, vbat}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rectifier_adc_sequencer.md
RECTIFIER_ADC_SEQUENCER -- requirements
Module: rectifier_adc_sequencer

Interface
REQ-001 SHALL have parameter CONVST_W, default 4, CONVST_n low pulse width in clock cycles (1..15).
REQ-002 SHALL have parameter RD_W, default 3, CS_n/RD_n low width in cycles before the data latch (1..15).
REQ-003 SHALL have parameter TIMEOUT, default 200, maximum cycles spent waiting for EOC per channel (1..255).
REQ-004 SHALL have port i_clock, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port i_trigger, input, 1, level-sampled request to start one frame (Ibat, then Vbat).
REQ-007 SHALL have port i_clear_err, input, 1, clears the sticky timeout flags.
REQ-008 SHALL have port i_ADC_EOC_n, input, 2, asynchronous end-of-conversion, active low; bit0 is the Ibat ADC, bit1 the Vbat ADC.
REQ-009 SHALL have port i_ADC_DB, input, 8, data bus shared by both AD7822 devices.
REQ-010 SHALL have port o_ADC_CONVST_n, output, 2, per-ADC convert start, active low.
REQ-011 SHALL have port o_ADC_CS_n, output, 2, per-ADC chip select, active low.
REQ-012 SHALL have port o_ADC_RD_n, output, 2, per-ADC read strobe, active low.
REQ-013 SHALL have port o_Ibat_ADC, output, 8, last valid Ibat code.
REQ-014 SHALL have port o_Vbat_ADC, output, 8, last valid Vbat code.
REQ-015 SHALL have port o_valid, output, 1, one-cycle pulse at the end of each frame.
REQ-016 SHALL have port o_busy, output, 1, high whenever the FSM is not in IDLE.
REQ-017 SHALL have port o_timeout, output, 2, sticky per-channel EOC timeout flags.

Function
REQ-018 SHALL pass i_ADC_EOC_n through a 2-flop synchronizer per bit; all EOC decisions SHALL use the synchronized value.
REQ-019 SHALL implement the states IDLE, CONV, WAIT_EOC, READ, NEXT, DONE, with channel index ch in {0,1}.
REQ-020 IDLE: when i_trigger=1, go to CONV with ch=0 on the next cycle; otherwise remain in IDLE.
REQ-021 CONV: drive o_ADC_CONVST_n[ch]=0 for exactly CONVST_W cycles, then go to WAIT_EOC with the timeout counter cleared.
REQ-022 WAIT_EOC: when synchronized EOC_n[ch]=0, go to READ.
REQ-023 WAIT_EOC timeout: if TIMEOUT cycles elapse without EOC, set o_timeout[ch], leave the ch output register unchanged, and go to NEXT.
REQ-024 READ: drive o_ADC_CS_n[ch]=0 and o_ADC_RD_n[ch]=0 for exactly RD_W cycles; on the last READ cycle, latch i_ADC_DB into o_Ibat_ADC (ch=0) or o_Vbat_ADC (ch=1); then go to NEXT.
REQ-025 NEXT: all strobes high for one cycle; if ch=0, set ch=1 and go to CONV; if ch=1, go to DONE.
REQ-026 DONE: assert o_valid for one cycle, then go to IDLE; o_valid SHALL pulse even if a timeout occurred during the frame.
REQ-027 SHALL ignore i_trigger outside IDLE (no queuing); with i_trigger held high, the next frame SHALL start on the cycle after DONE→IDLE.
REQ-028 SHALL never assert strobes for both channels in the same cycle.
REQ-029 SHALL never assert CS_n/RD_n low for either channel while its CONVST_n is low.
REQ-030 i_clear_err SHALL clear o_timeout to 0; if it coincides with a new timeout, the set SHALL win.
REQ-031 Counters SHALL be 8 bits wide and SHALL saturate rather than wrap.

Reset
REQ-032 While i_reset=1: state=IDLE, ch=0, o_ADC_CONVST_n=2'b11, o_ADC_CS_n=2'b11, o_ADC_RD_n=2'b11, o_Ibat_ADC=0, o_Vbat_ADC=0, o_valid=0, o_busy=0, o_timeout=0, synchronizer flops=1.
REQ-033 Reset asserted mid-frame SHALL abort the frame on the next edge with no latch and no o_valid pulse, and all strobes SHALL be high on that edge.

Verification
REQ-034 Single trigger, ADC models assert EOC 10 cycles after CONVST rises, DB=0x5A then 0xC3 -> CONVST 4 cycles, RD 3 cycles, o_Ibat_ADC=0x5A, o_Vbat_ADC=0xC3, one o_valid pulse, o_timeout=0.
REQ-035 Vbat EOC held high -> o_timeout=2'b10 after 200 wait cycles, o_Vbat_ADC keeps its prior value, o_valid still pulses; then i_clear_err -> o_timeout=0.
REQ-036 i_trigger held high for 3 frames -> back-to-back frames with exactly 1 IDLE cycle between them and 3 o_valid pulses.
REQ-037 i_reset asserted during READ of ch=1 -> strobes high on the next edge, o_Vbat_ADC unchanged from its reset value, no o_valid pulse.
REQ-038 Trigger pulses while o_busy=1 -> ignored, only one frame executed.
REQ-039 Every cycle (assertion): never more than one CONVST_n/CS_n bit low, and CS_n==RD_n per bit.
